// File: rtl/light_show_scheduler.sv
// rtl/light_show_scheduler.sv - round-robin sequencer of go/finished light shows onto one light bus
//
// Optional feature macro: SCHED_WATCHDOG_EN
//   defined   : a show still running after TIMEOUT_MS is abandoned like a skip;
//               adds the sticky timeout_flag output
//   undefined : RUN waits for finished or skip indefinitely; there is no timeout_flag port
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   enable         level, high keeps scheduling shows
//   skip           pulse, abandon display of the current show
//   show_mask      per-show participation enable, sampled only while selecting
//   show_finished  one-cycle done pulse from each show
//   show_lights    lights of show i at bits [8i+7:8i]
//   show_go        one-cycle launch pulse, at most one bit set
//   lights         physical light drive
//   active_idx     index of the show being displayed
//   busy           high whenever the scheduler is not idle
//   cycle_done     one-cycle pulse when the round-robin wraps
//   timeout_flag   (SCHED_WATCHDOG_EN only) sticky watchdog indication
module light_show_scheduler #(
    parameter int NUM_SHOWS   = 4,
    parameter int CLKS_PER_MS = 5000,
    parameter int GAP_MS      = 2000,
    parameter int TIMEOUT_MS  = 600000,
    localparam int IDXW       = $clog2(NUM_SHOWS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   skip,
    input  logic [NUM_SHOWS-1:0]   show_mask,
    input  logic [NUM_SHOWS-1:0]   show_finished,
    input  logic [NUM_SHOWS*8-1:0] show_lights,
    output logic [NUM_SHOWS-1:0]   show_go,
    output logic [7:0]             lights,
    output logic [IDXW-1:0]        active_idx,
    output logic                   busy,
    output logic                   cycle_done
`ifdef SCHED_WATCHDOG_EN
    ,
    output logic                   timeout_flag
`endif
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_LAUNCH, S_RUN, S_GAP} state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [PW-1:0]        r_pre;
    logic [19:0]          r_ms;
    logic [NUM_SHOWS-1:0] r_running;
    logic [IDXW-1:0]      r_active_idx;
    logic [IDXW-1:0]      r_last_idx;
    logic                 r_first;
    logic                 r_cycle_done;
    logic [7:0]           r_lights;

    logic                 w_tick;
    logic                 w_found;
    logic                 w_wrap;
    logic                 w_fin_act;
    logic                 w_timeout;
    logic [IDXW-1:0]      w_found_idx;
    logic [NUM_SHOWS-1:0] w_cand;
    logic [7:0]           w_act_lights;

    // Free-running millisecond prescaler.
    assign w_tick = (r_pre == PW'(CLKS_PER_MS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
        end
    end

    // Shows that are still busy internally (e.g. skipped ones) are not eligible.
    assign w_cand       = show_mask & ~r_running;
    assign w_wrap       = (w_found_idx <= r_last_idx) && !r_first;
    assign w_fin_act    = show_finished[r_active_idx];
    assign w_act_lights = show_lights[{r_active_idx, 3'b000} +: 8];

    // Round-robin search starting just after the last launched show.
    always_comb begin
        int j;
        j           = 0;
        w_found     = 1'b0;
        w_found_idx = '0;
        for (int k = 1; k <= NUM_SHOWS; k++) begin
            j = (int'(r_last_idx) + k) % NUM_SHOWS;
            if (!w_found && w_cand[j]) begin
                w_found     = 1'b1;
                w_found_idx = IDXW'(j);
            end
        end
    end

`ifdef SCHED_WATCHDOG_EN
    logic r_timeout_flag;

    assign w_timeout = (r_state == S_RUN) && w_tick && (r_ms == 20'(TIMEOUT_MS - 1));

    // A finished pulse on the timeout tick wins, so the flag only marks real hangs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_flag <= 1'b0;
        end else if (r_state == S_LAUNCH) begin
            r_timeout_flag <= 1'b0;
        end else if (w_timeout && !w_fin_act) begin
            r_timeout_flag <= 1'b1;
        end
    end

    assign timeout_flag = r_timeout_flag;
`else
    // Constant 0: the watchdog path is not built.
    assign w_timeout = (TIMEOUT_MS < 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic. Gap and timeout fire on the tick that brings the ms count to the limit.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_state_nx = S_SELECT;
            S_SELECT: begin
                if (w_found)     w_state_nx = S_LAUNCH;
                else if (enable) w_state_nx = S_GAP;
                else             w_state_nx = S_IDLE;
            end
            S_LAUNCH: w_state_nx = S_RUN;
            S_RUN:    if (w_fin_act || skip || w_timeout) w_state_nx = S_GAP;
            S_GAP: begin
                if (w_tick && (r_ms == 20'(GAP_MS - 1)))
                    w_state_nx = enable ? S_SELECT : S_IDLE;
            end
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        show_go = '0;
        if (r_state == S_LAUNCH) show_go[r_active_idx] = 1'b1;
        busy       = (r_state != S_IDLE);
        lights     = r_lights;
        active_idx = r_active_idx;
        cycle_done = r_cycle_done;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ms         <= '0;
            r_running    <= '0;
            r_active_idx <= '0;
            r_last_idx   <= IDXW'(NUM_SHOWS - 1);
            r_first      <= 1'b1;
            r_cycle_done <= 1'b0;
            r_lights     <= 8'h00;
        end else begin
            r_ms         <= (w_state_nx != r_state) ? '0 : r_ms + 20'(w_tick);
            // Set wins over a same-cycle finished pulse.
            r_running    <= show_go | (r_running & ~show_finished);
            r_cycle_done <= 1'b0;
            if (r_state == S_IDLE && enable) r_first <= 1'b1;
            if (r_state == S_SELECT && w_found) begin
                r_active_idx <= w_found_idx;
                r_last_idx   <= w_found_idx;
                r_first      <= 1'b0;
                r_cycle_done <= w_wrap;
            end
            // Blank on the cycle after the show is left so skip darkens immediately.
            r_lights <= (r_state == S_RUN && w_state_nx == S_RUN) ? w_act_lights : 8'h00;
        end
    end

endmodule
